// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared definitions for the interrupt controller: the handshake state
// machine encoding, the register offsets within the four-address window,
// the CTRL bit positions and the width of a source identifier.
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

   // Handshake with the processor: wait for work, pick a source, hold the
   // request line until acknowledged, then wait for end-of-interrupt.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SELECT   = 2'd1,
      RAISE    = 2'd2,
      WAIT_EOI = 2'd3
   } state_e;

   // Register offsets relative to BASE_ADDR.
   localparam logic [1:0] OFS_PENDING = 2'd0;
   localparam logic [1:0] OFS_MASK    = 2'd1;
   localparam logic [1:0] OFS_ACTIVE  = 2'd2;
   localparam logic [1:0] OFS_CTRL    = 2'd3;

   // CTRL register bits.
   localparam int CTRL_EN_BIT = 0;
   localparam int CTRL_RR_BIT = 1;

   // Source identifier width (up to eight sources).
   localparam int ID_W = 3;

endpackage

// File: rtl/irq_priority_picker.sv
// -----------------------------------------------------------------------------
// irq_priority_picker
// Combinational arbiter. In fixed mode the lowest set request wins; in
// round-robin mode the search starts just after last_id_i and wraps modulo
// N_SRC, so last_id_i itself is the final candidate.
//
// Ports:
//   req_i      [N_SRC-1:0]  requests (pending AND mask)
//   last_id_i  [ID_W-1:0]   most recently served source
//   rr_mode_i               1 = round-robin, 0 = fixed priority
//   id_o       [ID_W-1:0]   winning source (0 when none)
//   any_o                   at least one request present
// -----------------------------------------------------------------------------
module irq_priority_picker
   import irq_ctrl_pkg::*;
#(
   parameter int N_SRC = 4
) (
   input  logic [N_SRC-1:0] req_i,
   input  logic [ID_W-1:0]  last_id_i,
   input  logic             rr_mode_i,
   output logic [ID_W-1:0]  id_o,
   output logic             any_o
);

   int start;
   int idx;

   always_comb begin
      id_o  = '0;
      any_o = 1'b0;
      idx   = 0;
      start = rr_mode_i ? int'(last_id_i) + 1 : 0;
      // start + k never exceeds 2*N_SRC-1, so a single subtraction wraps it.
      for (int k = 0; k < N_SRC; k++) begin
         idx = start + k;
         if (idx >= N_SRC) begin
            idx = idx - N_SRC;
         end
         if (!any_o && req_i[idx]) begin
            id_o  = ID_W'(idx);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Merges up to eight level-held peripheral interrupt requests onto a single
// processor interrupt line. Requests are latched into PENDING (with a
// one-cycle ack back to the source), filtered by MASK, arbitrated, and
// presented to the processor through a raise/ack handshake closed by an
// end-of-interrupt write. Registers are exposed on a shared 8-bit bus.
//
// Ports:
//   CLK            system clock, rising edge
//   RESET          asynchronous active-low reset
//   BUS_DATA [7:0] shared data bus; driven for one cycle after a read
//   BUS_ADDR [7:0] shared address bus (window BASE_ADDR..BASE_ADDR+3)
//   BUS_WE         1 = write
//   SRC_IRQ_RAISE  per-source request level
//   SRC_IRQ_ACK    per-source one-cycle capture acknowledge
//   CPU_IRQ_RAISE  interrupt request to the processor
//   CPU_IRQ_ACK    processor acknowledge pulse
// -----------------------------------------------------------------------------
module irq_controller
   import irq_ctrl_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'hD0,
   parameter int         N_SRC     = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   inout  wire  [7:0]       BUS_DATA,
   input  logic [7:0]       BUS_ADDR,
   input  logic             BUS_WE,
   input  logic [N_SRC-1:0] SRC_IRQ_RAISE,
   output logic [N_SRC-1:0] SRC_IRQ_ACK,
   output logic             CPU_IRQ_RAISE,
   input  logic             CPU_IRQ_ACK
);

   state_e           state_q, state_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic             act_valid_q, act_valid_d;
   logic [ID_W-1:0]  act_id_q, act_id_d;
   logic [ID_W-1:0]  last_id_q, last_id_d;
   logic [N_SRC-1:0] ack_q, ack_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_en_q, rd_en_d;

   // ---------------------------------------------------------------- decode
   logic [7:0] offset;
   logic       hit, rd_cyc, wr_cyc;
   logic       wr_pend, wr_mask, wr_active, wr_ctrl;
   logic       unused_bus;

   assign offset    = BUS_ADDR - BASE_ADDR;
   assign hit       = (offset < 8'd4);
   assign rd_cyc    = hit && !BUS_WE;
   assign wr_cyc    = hit && BUS_WE;
   assign wr_pend   = wr_cyc && (offset[1:0] == OFS_PENDING);
   assign wr_mask   = wr_cyc && (offset[1:0] == OFS_MASK);
   assign wr_active = wr_cyc && (offset[1:0] == OFS_ACTIVE);
   assign wr_ctrl   = wr_cyc && (offset[1:0] == OFS_CTRL);
   assign unused_bus = ^BUS_DATA;

   // ---------------------------------------------------------------- picker
   logic [ID_W-1:0] pick_id;
   logic            pick_any;

   irq_priority_picker #(.N_SRC(N_SRC)) u_picker (
      .req_i     (pend_q & mask_q),
      .last_id_i (last_id_q),
      .rr_mode_i (ctrl_q[CTRL_RR_BIT]),
      .id_o      (pick_id),
      .any_o     (pick_any)
   );

   // ---------------------------------------------------- next-state logic
   logic [N_SRC-1:0] capture, pend_clr, w1c;

   // NOTE: every signal driven here gets a default before the case/if
   // branches; any path that skipped an assignment would infer a latch.
   always_comb begin
      state_d     = state_q;
      act_valid_d = act_valid_q;
      act_id_d    = act_id_q;
      last_id_d   = last_id_q;
      mask_d      = mask_q;
      ctrl_d      = ctrl_q;
      rd_data_d   = 8'h00;
      rd_en_d     = rd_cyc;
      pend_clr    = '0;

      case (state_q)
         IDLE: begin
            if (ctrl_q[CTRL_EN_BIT] && (|(pend_q & mask_q))) begin
               state_d = SELECT;
            end
         end
         SELECT: begin
            // A same-edge W1C or mask write can leave nothing to pick.
            if (pick_any) begin
               act_valid_d = 1'b1;
               act_id_d    = pick_id;
               last_id_d   = pick_id;
               pend_clr    = N_SRC'(1) << pick_id;
               state_d     = RAISE;
            end else begin
               state_d = IDLE;
            end
         end
         RAISE: begin
            if (CPU_IRQ_ACK) begin
               state_d = WAIT_EOI;
            end
         end
         WAIT_EOI: begin
            if (wr_active) begin
               act_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Only bits not already pending are captured, so the ack fires once per
      // request; a capture overrides a W1C of the same bit.
      capture = SRC_IRQ_RAISE & ~pend_q;
      w1c     = wr_pend ? BUS_DATA[N_SRC-1:0] : '0;
      pend_d  = (pend_q & ~w1c & ~pend_clr) | capture;
      ack_d   = capture;

      if (wr_mask) mask_d = BUS_DATA[N_SRC-1:0];
      if (wr_ctrl) ctrl_d = BUS_DATA[1:0];

      if (rd_cyc) begin
         case (offset[1:0])
            OFS_PENDING: rd_data_d = 8'(pend_q);
            OFS_MASK:    rd_data_d = 8'(mask_q);
            OFS_ACTIVE:  rd_data_d = {act_valid_q, 4'b0000, act_id_q};
            default:     rd_data_d = {6'b000000, ctrl_q};
         endcase
      end
   end

   // ---------------------------------------------------------------- state
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         mask_q      <= '0;
         ctrl_q      <= '0;
         act_valid_q <= 1'b0;
         act_id_q    <= '0;
         last_id_q   <= '0;
         ack_q       <= '0;
         rd_data_q   <= 8'h00;
         rd_en_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         mask_q      <= mask_d;
         ctrl_q      <= ctrl_d;
         act_valid_q <= act_valid_d;
         act_id_q    <= act_id_d;
         last_id_q   <= last_id_d;
         ack_q       <= ack_d;
         rd_data_q   <= rd_data_d;
         rd_en_q     <= rd_en_d;
      end
   end

   // -------------------------------------------------------------- outputs
   assign SRC_IRQ_ACK   = ack_q;
   assign CPU_IRQ_RAISE = (state_q == RAISE);
   assign BUS_DATA      = rd_en_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

   localparam logic [7:0] BASE = 8'hD0;
   localparam int         N    = 4;
   localparam int         FULL = (1 << N) - 1;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [7:0]   bus_addr;
   logic         bus_we;
   logic         bus_drv;
   logic [7:0]   bus_wdata;
   wire  [7:0]   bus_data;
   logic [N-1:0] src_raise;
   logic [N-1:0] src_ack;
   logic         cpu_raise;
   logic         cpu_ack;
   logic [N-1:0] hold;

   assign bus_data = bus_drv ? bus_wdata : 8'hzz;

   irq_controller #(.BASE_ADDR(BASE), .N_SRC(N)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .BUS_DATA      (bus_data),
      .BUS_ADDR      (bus_addr),
      .BUS_WE        (bus_we),
      .SRC_IRQ_RAISE (src_raise),
      .SRC_IRQ_ACK   (src_ack),
      .CPU_IRQ_RAISE (cpu_raise),
      .CPU_IRQ_ACK   (cpu_ack)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural reference: register contents as integers, the handshake as
   // a phase number (0 waiting, 1 arbitrating, 2 requesting, 3 in service).
   // ------------------------------------------------------------------
   int m_pend, m_mask, m_ctrl, m_valid, m_id, m_last, m_phase;
   int m_ack, m_cpu, m_rd_valid, m_rd_data;

   function automatic int reg_value(input int ofs);
      case (ofs)
         0: return m_pend;
         1: return m_mask;
         2: return (m_valid << 7) | m_id;
         default: return m_ctrl;
      endcase
   endfunction

   function automatic int pick(input int req, input int rr, input int last);
      if (rr != 0) begin
         for (int k = 1; k <= N; k++)
            if (req[(last + k) % N]) return (last + k) % N;
      end else begin
         for (int i = 0; i < N; i++)
            if (req[i]) return i;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = 0; m_mask = 0; m_ctrl = 0; m_valid = 0; m_id = 0; m_last = 0;
      m_phase = 0; m_ack = 0; m_cpu = 0; m_rd_valid = 0; m_rd_data = 0;
   endtask

   task automatic model_step();
      int ofs, req, clr, cap, w1c, wd, nxt;
      bit hit;
      ofs = (int'(bus_addr) - int'(BASE)) & 255;
      hit = (ofs < 4);
      wd  = int'(bus_wdata);
      m_rd_valid = (hit && !bus_we) ? 1 : 0;
      if (m_rd_valid != 0) m_rd_data = reg_value(ofs);
      clr = 0;
      nxt = m_phase;
      case (m_phase)
         0: if ((m_ctrl & 1) != 0 && (m_pend & m_mask) != 0) nxt = 1;
         1: begin
            req = m_pend & m_mask;
            if (req != 0) begin
               m_id = pick(req, (m_ctrl >> 1) & 1, m_last);
               m_valid = 1;
               m_last = m_id;
               clr = 1 << m_id;
               nxt = 2;
            end else nxt = 0;
         end
         2: if (cpu_ack) nxt = 3;
         default: if (hit && bus_we && ofs == 2) begin m_valid = 0; nxt = 0; end
      endcase
      m_phase = nxt;
      cap = int'(src_raise) & ~m_pend & FULL;
      w1c = (hit && bus_we && ofs == 0) ? (wd & FULL) : 0;
      m_pend = ((m_pend & ~w1c & ~clr) | cap) & FULL;
      if (hit && bus_we && ofs == 1) m_mask = wd & FULL;
      if (hit && bus_we && ofs == 3) m_ctrl = wd & 3;
      m_ack = cap;
      m_cpu = (m_phase == 2) ? 1 : 0;
   endtask

   // Compare every cycle on the falling edge.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("src_ack", int'(src_ack), m_ack);
         check("cpu_raise", int'(cpu_raise), m_cpu);
         if (m_rd_valid != 0) check("bus_rdata", int'(bus_data), m_rd_data);
      end
   end

   // ------------------------------------------------------------------
   // Drivers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge CLK);
      if (RESET) model_step();
      #2;
      // Sources drop their request once acknowledged unless held.
      src_raise = src_raise & ~(src_ack & ~hold);
   endtask

   task automatic bus_idle();
      bus_addr = 8'h00; bus_we = 1'b0; bus_drv = 1'b0; bus_wdata = 8'h00;
   endtask

   task automatic bus_write(input int ofs, input int data);
      bus_addr = BASE + 8'(ofs); bus_we = 1'b1; bus_drv = 1'b1; bus_wdata = 8'(data);
      tick();
      bus_idle();
   endtask

   task automatic bus_read(input int ofs, output int data);
      bus_addr = BASE + 8'(ofs); bus_we = 1'b0; bus_drv = 1'b0;
      tick();
      bus_idle();
      data = int'(bus_data);
      tick();
   endtask

   task automatic wait_raise(output bit ok);
      int n;
      n = 0;
      while (!cpu_raise && n < 40) begin tick(); n++; end
      ok = cpu_raise;
      if (!ok) begin
         n_vec++; n_bad++;
         $display("FAIL wait_raise: CPU_IRQ_RAISE not seen within 40 cycles at %0t", $time);
      end
   endtask

   task automatic serve(output int id);
      bit ok;
      int a;
      id = -1;
      wait_raise(ok);
      if (!ok) return;
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      bus_read(2, a);
      check("serve_valid", a >> 7, 1);
      id = a & 7;
      bus_write(2, 0);
   endtask

   initial begin
      int d, id0, id1;
      bit ok, last_read, owes;
      int r;

      RESET = 1'b0; cpu_ack = 1'b0; src_raise = '0; hold = '0;
      bus_idle();
      model_reset();
      chk_en = 1;
      repeat (3) @(posedge CLK);
      #2 RESET = 1'b1;

      // Reset values of all four registers.
      for (int i = 0; i < 4; i++) begin
         bus_read(i, d);
         check("reset_reg", d, 0);
      end

      // Capture with everything masked: pending + ack, no CPU request.
      src_raise[2] = 1'b1;
      tick();
      check("ack_bit2", int'(src_ack), 4);
      repeat (3) tick();
      check("masked_no_raise", int'(cpu_raise), 0);
      bus_read(0, d);
      check("pending_bit2", d, 8'h04);
      bus_write(0, 8'h04);
      bus_read(0, d);
      check("pending_w1c", d, 0);

      // Minimum latency, ack, ACTIVE and EOI.
      bus_write(1, 8'h0F);
      bus_write(3, 8'h01);
      src_raise[1] = 1'b1;
      tick();
      check("ack_bit1", int'(src_ack), 2);
      tick();
      check("latency_e1", int'(cpu_raise), 0);
      tick();
      check("latency_e2", int'(cpu_raise), 1);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      check("raise_drop_on_ack", int'(cpu_raise), 0);
      bus_read(2, d);
      check("active_in_service", d, 8'h81);
      bus_write(2, 0);
      bus_read(2, d);
      check("active_after_eoi", d, 8'h01);

      // Fixed priority: 0 before 3.
      src_raise = 4'b1001;
      serve(id0);
      serve(id1);
      check("fixed_first", id0, 0);
      check("fixed_second", id1, 3);

      // Round-robin: make last_id 0, then pending 0x09 serves 3 before 0.
      bus_write(3, 8'h03);
      src_raise[0] = 1'b1;
      serve(id0);
      check("rr_prime", id0, 0);
      bus_write(3, 8'h02);
      src_raise = 4'b1001;
      repeat (3) tick();
      bus_read(0, d);
      check("rr_pending", d, 8'h09);
      bus_write(3, 8'h03);
      serve(id0);
      serve(id1);
      check("rr_first", id0, 3);
      check("rr_second", id1, 0);

      // Capture and W1C of the same bit on the same edge: capture wins.
      bus_write(3, 8'h00);
      src_raise[2] = 1'b1;
      bus_write(0, 8'h04);
      bus_read(0, d);
      check("set_beats_w1c", d, 8'h04);
      bus_write(0, 8'h04);

      // Asynchronous reset while requesting the CPU.
      bus_write(3, 8'h01);
      hold = 4'b1000;
      src_raise = 4'b1010;
      wait_raise(ok);
      RESET = 1'b0;
      model_reset();
      #1;
      check("rst_cpu_raise", int'(cpu_raise), 0);
      check("rst_src_ack", int'(src_ack), 0);
      tick(); tick();
      RESET = 1'b1;
      tick();
      check("recapture_ack", int'(src_ack), 8);
      bus_read(1, d); check("rst_mask", d, 0);
      bus_read(2, d); check("rst_active", d, 0);
      bus_read(3, d); check("rst_ctrl", d, 0);
      bus_read(0, d); check("recapture_pend", d, 8'h08);
      hold = '0; src_raise = '0;
      bus_write(0, 8'h08);

      // Randomized traffic against the model.
      bus_write(1, 8'h0F);
      bus_write(3, 8'h01);
      last_read = 0; owes = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++)
            if (!src_raise[i] && $urandom_range(0, 9) == 0) src_raise[i] = 1'b1;
         cpu_ack = 1'b0;
         if (cpu_raise && $urandom_range(0, 2) == 0) cpu_ack = 1'b1;
         else if ($urandom_range(0, 63) == 0) cpu_ack = 1'b1;
         if (cpu_ack && cpu_raise) owes = 1;
         bus_idle();
         if (last_read) begin
            last_read = 0;   // leave the bus to the read data
         end else if (owes && $urandom_range(0, 3) == 0) begin
            bus_addr = BASE + 8'd2; bus_we = 1'b1; bus_drv = 1'b1;
            bus_wdata = 8'($urandom);
            owes = 0;
         end else begin
            r = $urandom_range(0, 15);
            if (r >= 5 && r <= 8) begin
               bus_addr = (r == 8) ? (($urandom_range(0, 1) == 0) ? BASE - 8'd1 : BASE + 8'd4)
                                   : BASE + 8'($urandom_range(0, 3));
               last_read = 1;
            end else if (r >= 9 && r <= 13) begin
               bus_we = 1'b1; bus_drv = 1'b1;
               case (r)
                  9:  begin bus_addr = BASE + 8'd1; bus_wdata = 8'($urandom | 32'h1); end
                  10: begin
                     bus_addr = BASE + 8'd3;
                     bus_wdata = {6'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0)};
                  end
                  11: begin bus_addr = BASE; bus_wdata = 8'($urandom); end
                  12: begin bus_addr = BASE + 8'd2; bus_wdata = 8'($urandom); end
                  default: begin bus_addr = BASE + 8'd4 + 8'($urandom_range(0, 7)); bus_wdata = 8'($urandom); end
               endcase
            end
         end
         tick();
      end
      cpu_ack = 1'b0;
      bus_idle();
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
# irq_controller

Bus-mapped interrupt controller that merges up to eight peripheral interrupt sources (timer, mouse, IR, buttons, etc.) onto a single processor interrupt line. It latches source requests, applies a mask, arbitrates by fixed or round-robin priority, drives the raise/ack handshake to the processor, and exposes pending/mask/active-ID registers on the shared 8-bit data bus. It sits between the peripherals and one processor interrupt input, freeing the other input for expansion.

## Interface
- BASE_ADDR, 8'hD0, first of four consecutive bus addresses (BASE..BASE+3).
- N_SRC, 4, number of sources; legal range 1..8; unused register bits read 0.
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- BUS_DATA  inout  8  shared data bus; driven only during this block's read cycle, else high-Z.
- BUS_ADDR  input  8  shared address bus.
- BUS_WE  input  1  bus write enable, high = write.
- SRC_IRQ_RAISE  input  N_SRC  per-source request; level, held by source until its ack.
- SRC_IRQ_ACK  output  N_SRC  one-cycle pulse per source when its request is latched.
- CPU_IRQ_RAISE  output  1  interrupt request to processor.
- CPU_IRQ_ACK  input  1  processor acknowledge (one-cycle pulse).

## Operation
- Registers:
  - BASE+0 PENDING: read; write-1-to-clear.
  - BASE+1 MASK: R/W; 1 = enabled.
  - BASE+2 ACTIVE: read returns {valid, 4'b0, id[2:0]}; any write = end-of-interrupt (EOI).
  - BASE+3 CTRL: bit0 global enable, bit1 round-robin mode (0 = fixed, lowest index wins); other bits read 0.
- Reset values: PENDING, MASK, CTRL = 0; ACTIVE = 0; all outputs 0; BUS_DATA high-Z.
- Capture: on each edge, for every i with SRC_IRQ_RAISE[i]=1 and PENDING[i]=0, set PENDING[i] and pulse SRC_IRQ_ACK[i] (registered, one cycle). The source drops its raise after the ack. A set and a W1C on the same bit in the same cycle: set wins.
- FSM:
  - IDLE: if CTRL.0 and (PENDING & MASK) ≠ 0 → SELECT.
  - SELECT: the picker chooses id. Fixed mode: lowest set index. Round-robin mode: first set index after last_id, wrapping modulo N_SRC. Latch ACTIVE = {1, id}; clear PENDING[id]; last_id <= id → RAISE.
  - RAISE: CPU_IRQ_RAISE = 1; on CPU_IRQ_ACK → WAIT_EOI (raise deasserts the same edge).
  - WAIT_EOI: on write to BASE+2, clear ACTIVE.valid → IDLE.
- Masking or disabling affects only the IDLE→SELECT decision. An in-flight interrupt completes normally.
- A W1C to PENDING[id] during SELECT is irrelevant, because the bit is already being cleared.
- An EOI write outside WAIT_EOI is ignored.
- Bus read: when BUS_ADDR is in range and BUS_WE=0, the register value is captured at the edge and BUS_DATA is driven for the following cycle. Otherwise high-Z.
- Bus write: takes effect at the edge where BUS_WE=1 and the address matches.

## Timing
- Source raise sampled at edge E: PENDING set and SRC_IRQ_ACK pulses after E. The FSM (if IDLE, enabled, unmasked) enters SELECT at E+1 and RAISE at E+2. CPU_IRQ_RAISE is high from E+2, giving 2-cycle minimum latency.
- CPU_IRQ_ACK at edge A: CPU_IRQ_RAISE is low after A.
- EOI at edge W: the next SELECT occurs at W+1 at the earliest.
- Read latency: 1 cycle from address to data on BUS_DATA.
- Asynchronous reset mid-handshake: CPU_IRQ_RAISE and SRC_IRQ_ACK drop immediately. FSM → IDLE; all pending requests are lost. Sources still holding raise are re-captured after reset release.

## Structure
- Package irq_ctrl_pkg holds:
  - the state enum (IDLE, SELECT, RAISE, WAIT_EOI);
  - register offsets (OFS_PENDING=0, OFS_MASK=1, OFS_ACTIVE=2, OFS_CTRL=3);
  - CTRL bit indices.
- Sub-module irq_priority_picker is combinational: inputs req[N_SRC], last_id, rr_mode; outputs id and any.

## Test plan
- Reset, read BASE+0..3 → 0x00 each. SRC raise on bit 2 with MASK=0 → PENDING=0x04 and ack pulse, CPU_IRQ_RAISE stays 0.
- MASK=0x0F, CTRL=0x01, raise source 1 → CPU_IRQ_RAISE high 2 cycles after capture; ack; read ACTIVE → 0x81; EOI → ACTIVE=0x01.
- Fixed mode, sources 0 and 3 raised together → served order 0 then 3. Round-robin with last_id=0, pending 0x09 → 3 served before 0.
- Source 2 raised in the same cycle as W1C 0x04 to PENDING → PENDING bit 2 remains 1.
- Assert RESET low while in RAISE → CPU_IRQ_RAISE=0 immediately, all registers 0. Held source raise re-captured one cycle after release.
